mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
MEM-stage load/store unit; the consumer end of the decoded dcache_read / dcache_write / funct3 control fields.
- Turns a decoded memory op (ALU address, rs2 data) into a word-aligned data-cache request with byte mask and lane-replicated write data.
- Holds the request and stalls the pipeline until the cache responds.
- Returns load data aligned and sign/zero-extended for the regfile writeback mux.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported (mask is DATA_W/8 = 4 bits).

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  reset. Synchronous, active-high.
- mem_valid  in  1  MEM stage holds a valid instruction.
- dcache_read  in  1  control-word load request.
- dcache_write  in  1  control-word store request.
- funct3  in  3  access size/sign: lb/sb=000, lh/sh=001, lw/sw=010, lbu=100, lhu=101.
- addr  in  ADDR_W  byte address (ALU result).
- store_data  in  DATA_W  rs2 value.
- stall_out  out  1  freeze pipeline.
- load_data  out  DATA_W  formatted load result.
- load_valid  out  1  one-cycle pulse: load_data valid.
- misalign  out  1  misaligned-access flag (see Optional Feature).
- d_read  out  1  cache read strobe.
- d_write  out  1  cache write strobe.
- d_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- d_wdata  out  DATA_W  write data.
- d_mbe  out  4  byte mask.
- d_resp  in  1  cache done.
- d_rdata  in  DATA_W  cache read data.

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset: state=IDLE; all outputs 0. A reset in REQ drops d_read/d_write at that edge, with no load_valid.
- IDLE:
  - If mem_valid & (dcache_read|dcache_write): register d_addr, d_mbe, d_wdata, funct3, addr[1:0] and the op, then go REQ.
  - stall_out=1 combinationally in this cycle.
  - If neither strobe is set, stall_out=0 and the state stays IDLE.
- Both strobes high: read wins; the write is dropped.
- REQ:
  - d_read or d_write held high with stable registered address/data/mask. stall_out=1.
  - On d_resp: register the formatted d_rdata into load_data, go DONE. d_resp in the same cycle the strobe first rises is legal.
- DONE:
  - stall_out=0, so the pipeline advances. load_valid=1 for reads only. Strobes low.
  - Next state: IDLE. No request is accepted in DONE.
- Minimum latency: accept to DONE = 2 edges. Stall length = 2 + cache wait cycles.
- Byte mask, with off = addr[1:0]:
  - sb: 0001<<off.
  - sh: 0011<<{off[1],0}.
  - sw: 1111.
  - Reserved funct3 codes (011/110/111): treated as word.
  - Reads drive d_mbe=1111.
- Write data:
  - sb: store_data[7:0] replicated ×4.
  - sh: store_data[15:0] replicated ×2.
  - sw: store_data unchanged.
- Load format:
  - lb/lbu: byte at lane off, sign- or zero-extended.
  - lh/lhu: half at lane off[1], sign- or zero-extended.
  - lw: full word.
- Without the feature, addr[0] is ignored for halves and addr[1:0] for words (silent truncation).
- load_data holds its value until the next load completes.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Enabled:
  - Misaligned accesses are lh/lhu/sh with addr[0]=1, and lw/sw with addr[1:0]≠0.
  - In IDLE such an access goes directly to DONE: no d_read/d_write, stall_out=1 for one cycle.
  - misalign=1 and load_data=0 during DONE.
  - load_valid is still pulsed for loads.
- Disabled: misalign tied 0; truncation as above.

Test Plan:
- lb at addr 0x1003, d_rdata=0x80FF_0000, d_resp after 2 cycles → d_addr=0x1000, stall_out high 4 cycles, load_data=0xFFFF_FF80, load_valid one pulse.
- lhu at addr 0x2002, d_rdata=0xBEEF_1234, d_resp same cycle as d_read → load_data=0x0000_BEEF, total stall 2 cycles.
- sb 0xAB at addr 0x3001 → d_mbe=0010, d_wdata=0xABAB_ABAB, d_write held until d_resp, load_valid stays 0.
- sh store_data=0x1234_5678 at 0x4002, then back-to-back lw 0x4000 → d_mbe=1100, d_wdata=0x5678_5678; second request issued only after the DONE cycle.
- rst asserted in REQ while d_read high → next cycle d_read=0, stall_out=0, load_valid=0, state IDLE.
- With LSU_MISALIGN_TRAP_EN: lw at 0x5001 → no d_read, misalign=1 for one cycle, load_data=0; without the macro → d_addr=0x5000, normal read.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit.
// Accepts a decoded load/store and issues one word-aligned data-cache request
// with a byte mask and lane-replicated write data. It stalls the pipeline
// until the cache responds, then returns the aligned, extended load result.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// skip the cache and are flagged on misalign. Without the macro, low
// address bits are silently truncated.
module mem_stage_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall_out,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic              d_read,
    output logic              d_write,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    output logic [3:0]        d_mbe,
    input  logic              d_resp,
    input  logic [DATA_W-1:0] d_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              is_rd_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              d_read_q;
    logic              d_write_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [DATA_W-1:0] d_wdata_q;
    logic [3:0]        d_mbe_q;
    logic [DATA_W-1:0] load_data_q;
    logic              load_valid_q;
    logic              misalign_q;

    logic              accept_d;
    logic              mis_d;
    logic [3:0]        d_mbe_d;
    logic [DATA_W-1:0] d_wdata_d;
    logic [DATA_W-1:0] load_fmt_d;

    // Access size from funct3[1:0]: 00 byte, 01 half, anything else a word
    // (so reserved codes 011/110/111 behave as word accesses).
    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << {off[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] store_fmt(input logic [2:0] f3, input logic [DATA_W-1:0] sd);
        logic [DATA_W-1:0] w;
        case (f3[1:0])
            2'b00:   w = {4{sd[7:0]}};
            2'b01:   w = {2{sd[15:0]}};
            default: w = sd;
        endcase
        return w;
    endfunction

    // Pick the addressed lane and sign- or zero-extend it; funct3[2] marks unsigned.
    function automatic logic [DATA_W-1:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [DATA_W-1:0] rd);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic [DATA_W-1:0]  r;
        b_s = rd[{off, 3'b000} +: 8];
        h_s = rd[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = DATA_W'(b_s);
            3'b100:  r = {24'd0, b_s};
            3'b001:  r = DATA_W'(h_s);
            3'b101:  r = {16'd0, h_s};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign accept_d   = mem_valid & (dcache_read | dcache_write);
    assign d_mbe_d    = dcache_read ? 4'b1111 : byte_mask(funct3, addr[1:0]);
    assign d_wdata_d  = store_fmt(funct3, store_data);
    assign load_fmt_d = load_fmt(funct3_q, off_q, d_rdata);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_d = ((funct3[1:0] == 2'b01) & addr[0]) |
                   (funct3[1] & (addr[1:0] != 2'b00));
`else
    assign mis_d = 1'b0;
`endif

    // Stall while an access is being accepted and while the cache request is outstanding.
    assign stall_out  = ((state_q == IDLE) && accept_d) || (state_q == REQ);
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misalign   = misalign_q;
    assign d_read     = d_read_q;
    assign d_write    = d_write_q;
    assign d_addr     = d_addr_q;
    assign d_wdata    = d_wdata_q;
    assign d_mbe      = d_mbe_q;

    // Request FSM: capture the op in IDLE, hold the cache request in REQ, report in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            is_rd_q      <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            d_read_q     <= 1'b0;
            d_write_q    <= 1'b0;
            d_addr_q     <= '0;
            d_wdata_q    <= '0;
            d_mbe_q      <= 4'd0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    load_valid_q <= 1'b0;
                    misalign_q   <= 1'b0;
                    if (accept_d) begin
                        // Read wins when both strobes are set.
                        is_rd_q   <= dcache_read;
                        funct3_q  <= funct3;
                        off_q     <= addr[1:0];
                        d_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                        d_mbe_q   <= d_mbe_d;
                        d_wdata_q <= d_wdata_d;
                        if (mis_d) begin
                            // Trapped access never reaches the cache.
                            state_q      <= DONE;
                            misalign_q   <= 1'b1;
                            load_valid_q <= dcache_read;
                            load_data_q  <= '0;
                        end else begin
                            state_q   <= REQ;
                            d_read_q  <= dcache_read;
                            d_write_q <= ~dcache_read;
                        end
                    end
                end
                REQ: begin
                    if (d_resp) begin
                        state_q   <= DONE;
                        d_read_q  <= 1'b0;
                        d_write_q <= 1'b0;
                        if (is_rd_q) begin
                            load_data_q  <= load_fmt_d;
                            load_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    load_valid_q <= 1'b0;
                    misalign_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed vector table, hand sequences for multi-cycle
// corners (back-to-back, reset mid-request, misaligned word), and random
// transactions checked against a byte-lane arithmetic model.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        dcache_read;
    logic        dcache_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall_out;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mbe;
    logic        d_resp;
    logic [31:0] d_rdata;

    int          n_checks;
    int          n_errors;
    logic [31:0] last_load;

    mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall_out(stall_out), .load_data(load_data), .load_valid(load_valid),
        .misalign(misalign), .d_read(d_read), .d_write(d_write),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_mbe(d_mbe),
        .d_resp(d_resp), .d_rdata(d_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int ref_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // Byte offset of the naturally aligned container holding the access.
    function automatic int ref_lane(input logic [31:0] a, input int sz);
        return ((int'(a % 4)) / sz) * sz;
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] a, input logic rd);
        logic [3:0] m;
        int sz;
        int ln;
        if (rd) return 4'hF;
        sz = ref_size(f3);
        ln = ref_lane(a, sz);
        m = 4'h0;
        for (int k = 0; k < sz; k++) m[ln + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        longint u;
        longint w;
        longint one;
        int sz;
        one = 1;
        sz = ref_size(f3);
        u = longint'({32'd0, sd}) % (one << (8 * sz));
        w = 0;
        for (int k = 0; k < 4 / sz; k++) w = w + (u << (8 * sz * k));
        return w[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
        longint v;
        longint one;
        int sz;
        one = 1;
        sz = ref_size(f3);
        v = (longint'({32'd0, rdata}) >> (8 * ref_lane(a, sz))) % (one << (8 * sz));
        if (sz < 4 && (f3 == 3'b000 || f3 == 3'b001) && v >= (one << (8 * sz - 1)))
            v = v - (one << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % ref_size(f3)) != 0;
`else
        return (f3 == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // One complete transaction from IDLE back to IDLE.
    task automatic run_txn(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                           input int waitc, input logic [3:0] e_mbe, input logic [31:0] e_wdata,
                           input logic [31:0] e_load, input logic e_mis);
        int stalls;
        mem_valid = 1'b1; dcache_read = rd; dcache_write = wr;
        funct3 = f3; addr = a; store_data = sd;
        #1;
        stalls = int'(stall_out);
        @(posedge clk); #1;
        mem_valid = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        if (e_mis) begin
            chk({nm, " mis_stall"}, 32'(stalls), 32'd1);
            chk({nm, " mis_d_read"}, 32'(d_read), 32'd0);
            chk({nm, " mis_d_write"}, 32'(d_write), 32'd0);
            chk({nm, " mis_flag"}, 32'(misalign), 32'd1);
            chk({nm, " mis_stall_done"}, 32'(stall_out), 32'd0);
            chk({nm, " mis_load_data"}, load_data, 32'd0);
            chk({nm, " mis_load_valid"}, 32'(load_valid), 32'(rd));
            last_load = 32'd0;
        end else begin
            for (int c = 0; c <= waitc; c++) begin
                stalls += int'(stall_out);
                chk({nm, " d_read"}, 32'(d_read), 32'(rd));
                chk({nm, " d_write"}, 32'(d_write), 32'(!rd));
                chk({nm, " d_addr"}, d_addr, a & 32'hFFFF_FFFC);
                chk({nm, " d_mbe"}, 32'(d_mbe), 32'(e_mbe));
                if (!rd) chk({nm, " d_wdata"}, d_wdata, e_wdata);
                if (c == waitc) begin
                    d_resp = 1'b1; d_rdata = rdata;
                end else begin
                    d_rdata = $urandom;
                end
                @(posedge clk); #1;
                d_resp = 1'b0;
                d_rdata = $urandom;
            end
            chk({nm, " stall_len"}, 32'(stalls), 32'(2 + waitc));
            chk({nm, " done_stall"}, 32'(stall_out), 32'd0);
            chk({nm, " done_strobes"}, {30'd0, d_read, d_write}, 32'd0);
            chk({nm, " load_valid"}, 32'(load_valid), 32'(rd));
            chk({nm, " misalign"}, 32'(misalign), 32'd0);
            if (rd) last_load = e_load;
            chk({nm, " load_data"}, load_data, last_load);
        end
        @(posedge clk); #1;
        chk({nm, " idle_valid"}, 32'(load_valid), 32'd0);
        chk({nm, " idle_mis"}, 32'(misalign), 32'd0);
        chk({nm, " hold_data"}, load_data, last_load);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          waitc;
        logic [3:0]  e_mbe;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
    } vec_t;

    vec_t vt[10];

    initial begin
        int          op;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          waitc;
        logic        e_mis;
        logic [2:0]  wr_codes[6];

        n_checks = 0; n_errors = 0; last_load = 32'd0;
        rst = 1'b1; mem_valid = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; d_resp = 1'b0; d_rdata = 32'd0;
        wr_codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        //        rd wr f3      addr          store        rdata        wt mbe    wdata         load
        vt[0] = '{1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 2, 4'hF, 32'h0,        32'hFFFF_FF80};
        vt[1] = '{1, 0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 4'hF, 32'h0,        32'h0000_BEEF};
        vt[2] = '{0, 1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'h0,        1, 4'h2, 32'hABAB_ABAB, 32'h0};
        vt[3] = '{0, 1, 3'b001, 32'h0000_4002, 32'h1234_5678, 32'h0,        0, 4'hC, 32'h5678_5678, 32'h0};
        vt[4] = '{1, 0, 3'b001, 32'h0000_0010, 32'h0,        32'h0000_8001, 1, 4'hF, 32'h0,        32'hFFFF_8001};
        vt[5] = '{1, 0, 3'b100, 32'h0000_0021, 32'h0,        32'h1234_F6AA, 0, 4'hF, 32'h0,        32'h0000_00F6};
        vt[6] = '{1, 0, 3'b000, 32'h0000_0022, 32'h0,        32'h0056_0000, 3, 4'hF, 32'h0,        32'h0000_0056};
        vt[7] = '{0, 1, 3'b010, 32'h0000_0030, 32'hDEAD_BEEF, 32'h0,        1, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vt[8] = '{1, 1, 3'b010, 32'h0000_0040, 32'h5555_5555, 32'h1122_3344, 0, 4'hF, 32'h0,        32'h1122_3344};
        vt[9] = '{1, 0, 3'b011, 32'h0000_0050, 32'h0,        32'h89AB_CDEF, 1, 4'hF, 32'h0,        32'h89AB_CDEF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst stall_out", 32'(stall_out), 32'd0);
        chk("rst strobes", {30'd0, d_read, d_write}, 32'd0);
        chk("rst d_addr", d_addr, 32'd0);
        chk("rst d_wdata", d_wdata, 32'd0);
        chk("rst d_mbe", 32'(d_mbe), 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst flags", {30'd0, load_valid, misalign}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Idle with no strobe must not stall
        mem_valid = 1'b1;
        #1;
        chk("nostrobe stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("nostrobe d_read", 32'(d_read), 32'd0);
        chk("nostrobe stall2", 32'(stall_out), 32'd0);
        mem_valid = 1'b0;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].sd,
                    vt[i].rdata, vt[i].waitc, vt[i].e_mbe, vt[i].e_wdata, vt[i].e_load, 1'b0);
        end

        // Back-to-back: sh, then lw held through DONE; lw must wait for IDLE
        mem_valid = 1'b1; dcache_write = 1'b1; funct3 = 3'b001;
        addr = 32'h0000_4002; store_data = 32'h1234_5678;
        @(posedge clk); #1;
        chk("b2b sh mbe", 32'(d_mbe), 32'hC);
        chk("b2b sh wdata", d_wdata, 32'h5678_5678);
        chk("b2b sh d_write", 32'(d_write), 32'd1);
        d_resp = 1'b1;
        @(posedge clk); #1;
        d_resp = 1'b0;
        dcache_write = 1'b0; dcache_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_4000;
        chk("b2b done stall", 32'(stall_out), 32'd0);
        chk("b2b done d_read", 32'(d_read), 32'd0);
        chk("b2b done valid", 32'(load_valid), 32'd0);
        @(posedge clk); #1;
        chk("b2b idle d_read", 32'(d_read), 32'd0);
        chk("b2b idle stall", 32'(stall_out), 32'd1);
        @(posedge clk); #1;
        mem_valid = 1'b0; dcache_read = 1'b0;
        chk("b2b lw d_read", 32'(d_read), 32'd1);
        chk("b2b lw d_addr", d_addr, 32'h0000_4000);
        d_resp = 1'b1; d_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        d_resp = 1'b0;
        chk("b2b lw valid", 32'(load_valid), 32'd1);
        chk("b2b lw data", load_data, 32'hCAFE_F00D);
        last_load = 32'hCAFE_F00D;
        @(posedge clk); #1;

        // Reset while a read is outstanding
        mem_valid = 1'b1; dcache_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0060;
        @(posedge clk); #1;
        mem_valid = 1'b0; dcache_read = 1'b0;
        chk("rstreq d_read_before", 32'(d_read), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstreq d_read", 32'(d_read), 32'd0);
        chk("rstreq stall", 32'(stall_out), 32'd0);
        chk("rstreq valid", 32'(load_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstreq idle d_read", 32'(d_read), 32'd0);
        chk("rstreq idle valid", 32'(load_valid), 32'd0);
        chk("rstreq idle stall", 32'(stall_out), 32'd0);
        last_load = 32'd0;
        chk("rstreq load_data", load_data, 32'd0);

        // lw at 0x5001: trapped with the macro, truncated to 0x5000 without
`ifdef LSU_MISALIGN_TRAP_EN
        e_mis = 1'b1;
`else
        e_mis = 1'b0;
`endif
        run_txn("lw5001", 1'b1, 1'b0, 3'b010, 32'h0000_5001, 32'h0, 32'h1357_2468, 1,
                4'hF, 32'h0, 32'h1357_2468, e_mis);

        // Random transactions against the reference model
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 2));
            rd = (op != 1);
            wr = (op != 0);
            f3 = rd ? 3'($urandom_range(0, 7)) : wr_codes[$urandom_range(0, 5)];
            a = $urandom;
            sd = $urandom;
            rdata = $urandom;
            waitc = int'($urandom_range(0, 3));
            run_txn($sformatf("rnd%0d", i), rd, wr, f3, a, sd, rdata, waitc,
                    ref_mask(f3, a, rd), ref_wdata(f3, sd), ref_load(f3, a, rdata), ref_mis(f3, a));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
